sipo_comma_align: RTL

- Serial-in/parallel-out receive stage of the PMA. Sits directly downstream of the EWRAP loopback mux.
- Shifts in one bit per clock and hunts for the 7-bit comma (K28.5 prefix) to find code-group boundaries.
- Emits aligned 10-bit code groups with a one-cycle valid strobe to the PCS receive path.
- Tracks lock and realigns after repeated misaligned commas.

---
 rtl/sipo_comma_align_pkg.sv | 20 ++
 rtl/sipo_comma_align_if.sv | 29 ++
 rtl/sipo_comma_align_comma_detect.sv | 19 +
 rtl/sipo_comma_align.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sipo_comma_align_pkg.sv
// Shared PMA constants: code-group geometry, K28.5 comma prefixes, aligner states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sipo_comma_align_pkg;

  localparam int CG_WIDTH  = 10;
  localparam int COMMA_LEN = 7;

  // Bit k of each pattern is code-group bit k in transmission order (bit0 = a).
  localparam logic [COMMA_LEN-1:0] K28_5_COMMA_P = 7'b1111100;
  localparam logic [COMMA_LEN-1:0] K28_5_COMMA_N = 7'b0000011;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  typedef logic [CG_WIDTH-1:0] cg_t;

endpackage

// File: rtl/sipo_comma_align_if.sv
// Parallel receive bus from the comma aligner to the PCS receive path.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept every data_valid strobe.
interface sipo_comma_align_if;
  import sipo_comma_align_pkg::*;

  cg_t  data_out;
  logic data_valid;
  logic comma_det;
  logic locked;
  logic slip;

  modport master (
    output data_out,
    output data_valid,
    output comma_det,
    output locked,
    output slip
  );

  modport slave (
    input data_out,
    input data_valid,
    input comma_det,
    input locked,
    input slip
  );

endinterface

// File: rtl/sipo_comma_align_comma_detect.sv
// Combinational match of a 7-bit window against the positive/negative comma.
// Latency: zero (purely combinational).
// Backpressure: none.
module sipo_comma_align_comma_detect
  import sipo_comma_align_pkg::*;
#(
  parameter logic [COMMA_LEN-1:0] COMMA_P = K28_5_COMMA_P,
  parameter logic [COMMA_LEN-1:0] COMMA_N = K28_5_COMMA_N
) (
  input  logic [COMMA_LEN-1:0] win,
  output logic                 match
);

  // Either running-disparity form of the comma counts as a hit.
  always_comb begin
    match = (win == COMMA_P) || (win == COMMA_N);
  end

endmodule

// File: rtl/sipo_comma_align.sv
// Serial-in/parallel-out receiver that hunts for the K28.5 comma and emits aligned 10-bit groups.
// Latency: a group is registered at the edge that captures its last bit (j); valid is a 1-cycle strobe.
// Backpressure: none; optional SIPO_REALIGN_CNT_EN adds an 8-bit saturating lock/slip counter.
module sipo_comma_align
  import sipo_comma_align_pkg::*;
#(
  parameter int                   WIDTH       = CG_WIDTH,
  parameter logic [COMMA_LEN-1:0] COMMA_P     = K28_5_COMMA_P,
  parameter logic [COMMA_LEN-1:0] COMMA_N     = K28_5_COMMA_N,
  parameter int                   LOSS_THRESH = 3
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      serial_in,
  sipo_comma_align_if.master        rx
`ifdef SIPO_REALIGN_CNT_EN
  ,
  output logic [7:0]                realign_cnt
`endif
);

  cg_t          sr;
  cg_t          next_sr;
  logic [3:0]   bit_cnt;
  logic [3:0]   fill_cnt;
  logic [3:0]   miss_cnt;
  align_state_t state;

  logic         match;
  logic         window_full;
  logic         boundary;
  logic         miss_ok;
  logic         lock_evt;
  logic         slip_evt;

  // Newest bit enters at the top so that after ten shifts bit0 holds the oldest bit (a).
  always_comb begin
    next_sr = {serial_in, sr[CG_WIDTH-1:1]};
  end

  sipo_comma_align_comma_detect #(
    .COMMA_P (COMMA_P),
    .COMMA_N (COMMA_N)
  ) u_comma_detect (
    .win   (next_sr[COMMA_LEN-1:0]),
    .match (match)
  );

  // Decode alignment events from the current state and the incoming window.
  always_comb begin
    window_full = (fill_cnt == 4'(WIDTH));
    boundary    = (bit_cnt == 4'(WIDTH - 1));
    miss_ok     = (({1'b0, miss_cnt} + 5'd1) < 5'(LOSS_THRESH));
    lock_evt    = (state == HUNT) && match && window_full;
    slip_evt    = (state == LOCKED) && !boundary && match && !miss_ok;
  end

  // Shift register, fill gating, boundary counter, miss tracking and the HUNT/LOCKED FSM.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sr            <= '0;
      bit_cnt       <= '0;
      fill_cnt      <= '0;
      miss_cnt      <= '0;
      state         <= HUNT;
      rx.data_out   <= '0;
      rx.data_valid <= 1'b0;
      rx.comma_det  <= 1'b0;
      rx.locked     <= 1'b0;
      rx.slip       <= 1'b0;
    end else begin
      sr            <= next_sr;
      rx.data_valid <= 1'b0;
      rx.slip       <= 1'b0;
      if (!window_full) begin
        fill_cnt <= fill_cnt + 4'd1;
      end

      case (state)
        HUNT: begin
          // Reset zeros are still in the window until it has been filled once.
          if (lock_evt) begin
            rx.data_out   <= next_sr;
            rx.data_valid <= 1'b1;
            rx.comma_det  <= 1'b1;
            rx.locked     <= 1'b1;
            bit_cnt       <= '0;
            miss_cnt      <= '0;
            state         <= LOCKED;
          end
        end

        LOCKED: begin
          if (boundary) begin
            rx.data_out   <= next_sr;
            rx.data_valid <= 1'b1;
            rx.comma_det  <= match;
            bit_cnt       <= '0;
            if (match) begin
              miss_cnt <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            if (match) begin
              if (miss_ok) begin
                miss_cnt <= miss_cnt + 4'd1;
              end else begin
                // Too many off-boundary commas in a row: adopt this one as the new boundary.
                rx.data_out   <= next_sr;
                rx.data_valid <= 1'b1;
                rx.comma_det  <= 1'b1;
                rx.slip       <= 1'b1;
                bit_cnt       <= '0;
                miss_cnt      <= '0;
              end
            end
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

`ifdef SIPO_REALIGN_CNT_EN
  // Count lock acquisitions plus forced slips, holding at the top of the range.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      realign_cnt <= '0;
    end else if ((lock_evt || slip_evt) && (realign_cnt != 8'hFF)) begin
      realign_cnt <= realign_cnt + 8'd1;
    end
  end
`endif

endmodule
